// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared definitions for the programmable serial pattern detector:
// session FSM state encoding and default sizing parameters.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;  // longest pattern in bits
  localparam int DEF_LEN_W   = 4;  // width of cfg_len, holds DEF_MAX_LEN
  localparam int DEF_CNT_W   = 8;  // match counter / target width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_detect_ctrl_core.sv
// seq_match_core
// History shift register, saturating fill counter and a length-masked
// compare against the programmed pattern.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           synchronous clear of history and fill counter
//   shift_en      shift bit_in into history (LSB) this edge
//   bit_in        serial data bit
//   pattern, len  programmed pattern (bit [len-1] first received) and length
//   match         combinational; meaningful only while shift_en is high
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] hist_q, hist_nx, mask;
  logic [LEN_W-1:0]   fill_q, fill_nx;

  // Match is judged on the value history will hold after this edge, so the
  // completing bit itself takes part in the compare.
  always_comb begin
    hist_nx = {hist_q[MAX_LEN-2:0], bit_in};
    fill_nx = (fill_q < len) ? fill_q + 1'b1 : fill_q;
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match = shift_en && (fill_nx >= len) &&
            (((hist_nx ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_nx;
      fill_q <= fill_nx;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Session controller around seq_match_core. Accepts a pattern config over
// a valid/ready handshake, arms on start, counts overlapping matches on the
// qualified bitstream and finishes when the programmed target is reached.
// Handshake: a config transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high in every state except RUN. A
// transfer pre-empted by abort or start on the same edge is dropped.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready      config handshake
//   cfg_pattern/len/target   config payload (target 0 = unlimited)
//   cfg_err                  one-cycle pulse after an illegal cfg_len
//   start, abort             session control (abort wins)
//   data_valid, data         serial input
//   detected                 registered one-cycle match pulse
//   match_count              matches in current or last session
//   busy, done               decoded from state (RUN / DONE)
//   dbg_state                current FSM state
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  state_t state_q, state_d;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic               det_q, err_q;

  logic abort_eff, start_eff, cfg_take, cfg_legal, cfg_ok, cfg_bad;
  logic shift_en, match, hit;

  // Control strobes, encoding abort > start > config > data.
  always_comb begin
    abort_eff = abort && (state_q != IDLE);
    start_eff = start && !abort && ((state_q == LOADED) || (state_q == DONE));
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    cfg_take  = cfg_valid && cfg_ready && !abort_eff && !start_eff;
    cfg_ok    = cfg_take && cfg_legal;
    cfg_bad   = cfg_take && !cfg_legal;
    shift_en  = (state_q == RUN) && data_valid && !abort;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    hit       = match && (tgt_q != '0) && (cnt_inc == tgt_q);
  end

  seq_match_core #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_eff),
    .shift_en(shift_en),
    .bit_in  (data),
    .pattern (pat_q),
    .len     (len_q),
    .match   (match)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (abort_eff)                      state_d = IDLE;
    else if (start_eff)                 state_d = RUN;
    else if (cfg_ok)                    state_d = LOADED;
    else if ((state_q == RUN) && hit)   state_d = DONE;
  end

  // State-decoded outputs.
  always_comb begin
    cfg_ready = (state_q != RUN);
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Config latch, match counter and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      len_q <= '0;
      tgt_q <= '0;
      cnt_q <= '0;
      det_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= cfg_bad;
      det_q <= match;  // match is already gated off by abort via shift_en
      if (cfg_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        tgt_q <= cfg_target;
      end
      if (start_eff)  cnt_q <= '0;
      else if (match) cnt_q <= cnt_inc;
    end
  end

  assign detected    = det_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               cfg_err;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               data_valid = 1'b0;
  logic               data = 1'b0;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_err(cfg_err),
    .start(start), .abort(abort), .data_valid(data_valid), .data(data),
    .detected(detected), .match_count(match_count), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model (bench-side)
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  int                 m_tgt;
  int                 m_cnt;
  bit                 m_run;
  bit                 m_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int st, input int cnt);
    check({tag, "_state"}, 32'(dbg_state), 32'(st));
    check({tag, "_count"}, 32'(match_count), 32'(cnt));
    check({tag, "_busy"},  32'(busy), 32'(st == 2));
    check({tag, "_done"},  32'(done), 32'(st == 3));
  endtask

  task automatic send_cfg(input logic [MAX_LEN-1:0] pat, input int len, input int tgt);
    int waited = 0;
    bit legal;
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_target  = CNT_W'(tgt);
    while (!cfg_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    legal = (len >= 1) && (len <= MAX_LEN);
    check("cfg_err", 32'(cfg_err), 32'(!legal));
    if (legal) begin
      m_pat = pat; m_len = len; m_tgt = tgt; m_run = 0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_bits.delete();
    m_cnt = 0;
    m_run = 1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_run = 0;
  endtask

  // Model of one driven cycle; returns the expected detected pulse.
  function automatic bit model_step(input bit vld, input bit b);
    bit hit = 0;
    if (m_run && vld) begin
      m_bits.push_back(b);
      if (m_bits.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
      end
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_tgt != 0 && m_cnt == m_tgt) m_run = 0;
      end
    end
    return hit;
  endfunction

  task automatic send_bit(input bit vld, input bit b);
    data_valid = vld;
    data       = b;
    exp_q.push_back(model_step(vld, b));
    tick();
    data_valid = 1'b0;
    check("detected", 32'(detected), 32'(exp_q.pop_front()));
  endtask

  initial begin
    bit stream7[7];
    stream7 = '{1, 0, 0, 1, 0, 0, 1};
    m_pat = '0; m_len = 0; m_tgt = 0; m_cnt = 0; m_run = 0;

    // Reset
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_state("reset", 0, 0);
    check("reset_det", 32'(detected), 32'd0);
    check("reset_err", 32'(cfg_err), 32'd0);
    check("reset_rdy", 32'(cfg_ready), 32'd1);

    // Overlap
    send_cfg(8'b1001, 4, 0);
    check("loaded_state", 32'(dbg_state), 32'd1);
    do_start();
    check_state("run", 2, 0);
    check("run_rdy", 32'(cfg_ready), 32'd0);
    foreach (stream7[i]) send_bit(1, stream7[i]);
    check_state("overlap", 2, 2);
    do_abort();
    check_state("abort1", 0, 2);

    // Gaps
    send_cfg(8'b1001, 4, 0);
    do_start();
    foreach (stream7[i]) begin
      send_bit(1, stream7[i]);
      repeat (3) send_bit(0, $urandom_range(0, 1));
    end
    check_state("gaps", 2, 2);
    do_abort();

    // Target / DONE
    send_cfg(8'b11, 2, 3);
    do_start();
    repeat (4) send_bit(1, 1);
    check_state("target", 3, 3);
    check("done_rdy", 32'(cfg_ready), 32'd1);
    send_bit(1, 1);  // no shifting in DONE
    check("done_hold", 32'(match_count), 32'd3);
    do_start();
    check_state("restart", 2, 0);
    do_abort();

    // Illegal config
    send_cfg(8'h5, 0, 0);
    check("bad0_state", 32'(dbg_state), 32'd0);
    tick();
    check("err_one_cycle", 32'(cfg_err), 32'd0);
    send_cfg(8'h5, 9, 0);
    check("bad9_state", 32'(dbg_state), 32'd0);
    do_start();
    m_run = 0;
    check("idle_start", 32'(dbg_state), 32'd0);

    // Abort priority
    send_cfg(8'b1001, 4, 0);
    do_start();
    send_bit(1, 1); send_bit(1, 0); send_bit(1, 0);
    abort = 1'b1; start = 1'b1; data_valid = 1'b1; data = 1'b1;
    m_run = 0;
    exp_q.push_back(1'b0);
    tick();
    abort = 1'b0; start = 1'b0; data_valid = 1'b0;
    check("abort_det", 32'(detected), 32'(exp_q.pop_front()));
    check_state("abort_prio", 0, 0);

    // Random sessions
    for (int s = 0; s < 3; s++) begin
      send_cfg(MAX_LEN'($urandom_range(0, 255)), $urandom_range(1, MAX_LEN), 0);
      do_start();
      for (int k = 0; k < 60; k++)
        send_bit($urandom_range(0, 3) != 0, $urandom_range(0, 1));
      check("rand_count", 32'(match_count), 32'(m_cnt));
      do_abort();
    end

    // Reset mid-session
    send_cfg(8'b11, 2, 0);
    do_start();
    send_bit(1, 1);
    send_bit(1, 1);
    #2 rst = 1'b0;
    #1;
    check_state("async_rst", 0, 0);
    check("async_rst_det", 32'(detected), 32'd0);
    #2 rst = 1'b1;
    m_run = 0;
    tick();
    do_start();
    check_state("post_rst_start", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
